// File: rtl/duc_pkg.sv
// Shared types, default widths and the round/saturate helper for the x2 DUC mixer.
package duc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PRIME,
        ST_RUN
    } duc_state_t;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_DDS_WIDTH = 36;
    localparam int DEF_DDS_FRAC  = 34;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_DDS_LAT   = 4;

    // Wide enough for any sum of two IN_WIDTH x DDS_WIDTH products plus the rounding constant.
    localparam int ACC_W = 64;

    function automatic logic signed [ACC_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] x,
        input int                      frac,
        input int                      out_w
    );
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        logic signed [ACC_W-1:0] r;
        half = ACC_W'(1) <<< (frac - 1);
        hi   = (ACC_W'(1) <<< (out_w - 1)) - ACC_W'(1);
        lo   = -hi - ACC_W'(1);
        r    = (x + half) >>> frac;
        if (r > hi)      round_sat = hi;
        else if (r < lo) round_sat = lo;
        else             round_sat = r;
    endfunction

endpackage

// File: rtl/duc_cmac.sv
// One output phase of the mixer: product, sum, round and saturate stages (S2..S4).
// DUC_SPECTRAL_INVERT_EN selects y = I*cos + Q*sin instead of y = I*cos - Q*sin.
module duc_cmac
    import duc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int DDS_WIDTH = DEF_DDS_WIDTH,
    parameter int DDS_FRAC  = DEF_DDS_FRAC,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_en,
    input  logic signed [IN_WIDTH-1:0]  i_data_i,
    input  logic signed [IN_WIDTH-1:0]  i_data_q,
    input  logic signed [DDS_WIDTH-1:0] i_cos,
    input  logic signed [DDS_WIDTH-1:0] i_sin,
    output logic signed [OUT_WIDTH-1:0] o_data
);

    localparam int PROD_W = IN_WIDTH + DDS_WIDTH;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] p_ic_q;
    logic signed [PROD_W-1:0] p_qs_q;
    logic signed [SUM_W-1:0]  sum_q;

    // NOTE: the datapath is reset too, so o_data reads 0 after reset rather than X.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            p_ic_q <= '0;
            p_qs_q <= '0;
            sum_q  <= '0;
            o_data <= '0;
        end else if (i_en) begin
            p_ic_q <= PROD_W'(i_data_i) * PROD_W'(i_cos);
            p_qs_q <= PROD_W'(i_data_q) * PROD_W'(i_sin);
`ifdef DUC_SPECTRAL_INVERT_EN
            sum_q  <= SUM_W'(p_ic_q) + SUM_W'(p_qs_q);
`else
            sum_q  <= SUM_W'(p_ic_q) - SUM_W'(p_qs_q);
`endif
            o_data <= OUT_WIDTH'(round_sat(ACC_W'(sum_q), DDS_FRAC, OUT_WIDTH));
        end
    end

endmodule

// File: rtl/duc_mixer_x2.sv
// Two-sample-per-clock digital upconverter mixer with DDS priming FSM and global-stall pipeline.
// Build option DUC_SPECTRAL_INVERT_EN (in duc_cmac) selects the inverted-spectrum sum.
module duc_mixer_x2
    import duc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int DDS_WIDTH = DEF_DDS_WIDTH,
    parameter int DDS_FRAC  = DEF_DDS_FRAC,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int DDS_LAT   = DEF_DDS_LAT
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_nco_restart,
    input  logic signed [IN_WIDTH-1:0]  i_data_i0,
    input  logic signed [IN_WIDTH-1:0]  i_data_q0,
    input  logic signed [IN_WIDTH-1:0]  i_data_i1,
    input  logic signed [IN_WIDTH-1:0]  i_data_q1,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [DDS_WIDTH-1:0] i_cos,
    input  logic signed [DDS_WIDTH-1:0] i_sin,
    input  logic signed [DDS_WIDTH-1:0] i_cos_d,
    input  logic signed [DDS_WIDTH-1:0] i_sin_d,
    output logic                        o_dds_ready,
    output logic signed [OUT_WIDTH-1:0] o_data0,
    output logic signed [OUT_WIDTH-1:0] o_data1,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_primed
);

    localparam int CNT_W = (DDS_LAT > 1) ? $clog2(DDS_LAT) : 1;

    duc_state_t state;
    logic [CNT_W-1:0] prime_cnt;
    logic [3:0] valid_q;
    logic en;
    logic accept;

    logic signed [IN_WIDTH-1:0]  i0_q, q0_q, i1_q, q1_q;
    logic signed [DDS_WIDTH-1:0] cos0_q, sin0_q, cos1_q, sin1_q;

    assign o_valid     = valid_q[3];
    assign en          = !o_valid || i_ready;
    assign o_ready     = (state == ST_RUN) && en;
    assign accept      = o_ready && i_valid;
    // The NCO advances only on a real consume in RUN, or on each priming cycle.
    assign o_dds_ready = (state == ST_PRIME) || accept;

    // NOTE: every register here uses <= so all of them sample pre-edge values consistently.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            prime_cnt <= '0;
            o_primed  <= 1'b0;
        end else if (i_nco_restart) begin
            state    <= ST_WAIT;
            o_primed <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_WAIT: begin
                    state     <= ST_PRIME;
                    prime_cnt <= CNT_W'(DDS_LAT - 1);
                end
                ST_PRIME: begin
                    if (prime_cnt == '0) begin
                        state    <= ST_RUN;
                        o_primed <= 1'b1;
                    end else begin
                        prime_cnt <= prime_cnt - 1'b1;
                    end
                end
                ST_RUN: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= '0;
        end else if (i_nco_restart) begin
            valid_q <= '0;
        end else if (en) begin
            valid_q <= {valid_q[2:0], accept};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            i0_q   <= '0;
            q0_q   <= '0;
            i1_q   <= '0;
            q1_q   <= '0;
            cos0_q <= '0;
            sin0_q <= '0;
            cos1_q <= '0;
            sin1_q <= '0;
        end else if (en) begin
            i0_q   <= i_data_i0;
            q0_q   <= i_data_q0;
            i1_q   <= i_data_i1;
            q1_q   <= i_data_q1;
            cos0_q <= i_cos;
            sin0_q <= i_sin;
            cos1_q <= i_cos_d;
            sin1_q <= i_sin_d;
        end
    end

    duc_cmac #(
        .IN_WIDTH (IN_WIDTH),
        .DDS_WIDTH(DDS_WIDTH),
        .DDS_FRAC (DDS_FRAC),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_cmac0 (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_en     (en),
        .i_data_i (i0_q),
        .i_data_q (q0_q),
        .i_cos    (cos0_q),
        .i_sin    (sin0_q),
        .o_data   (o_data0)
    );

    duc_cmac #(
        .IN_WIDTH (IN_WIDTH),
        .DDS_WIDTH(DDS_WIDTH),
        .DDS_FRAC (DDS_FRAC),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_cmac1 (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_en     (en),
        .i_data_i (i1_q),
        .i_data_q (q1_q),
        .i_cos    (cos1_q),
        .i_sin    (sin1_q),
        .o_data   (o_data1)
    );

endmodule

// File: tb/tb_duc_mixer_x2.sv
// Scoreboard bench for duc_mixer_x2: priming, DC tone, saturation, rounding, backpressure, restart, reset.
module tb_duc_mixer_x2;

    localparam longint ONE  = longint'(1) <<< 34;
    localparam longint HALF = longint'(1) <<< 33;

    logic               i_clock = 1'b0;
    logic               i_reset_n;
    logic               i_nco_restart;
    logic signed [15:0] i_data_i0, i_data_q0, i_data_i1, i_data_q1;
    logic               i_valid;
    logic               o_ready;
    logic signed [35:0] i_cos, i_sin, i_cos_d, i_sin_d;
    logic               o_dds_ready;
    logic signed [15:0] o_data0, o_data1;
    logic               o_valid;
    logic               i_ready;
    logic               o_primed;

    duc_mixer_x2 dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_nco_restart(i_nco_restart),
        .i_data_i0    (i_data_i0),
        .i_data_q0    (i_data_q0),
        .i_data_i1    (i_data_i1),
        .i_data_q1    (i_data_q1),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_cos        (i_cos),
        .i_sin        (i_sin),
        .i_cos_d      (i_cos_d),
        .i_sin_d      (i_sin_d),
        .o_dds_ready  (o_dds_ready),
        .o_data0      (o_data0),
        .o_data1      (o_data1),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_primed     (o_primed)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        longint y0;
        longint y1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks   = 0;
    int failures = 0;
    int dds_cnt  = 0;
    int acc_cnt  = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint mix(input longint i, input longint q, input longint c, input longint s);
        longint acc;
`ifdef DUC_SPECTRAL_INVERT_EN
        acc = i * c + q * s;
`else
        acc = i * c - q * s;
`endif
        acc = (acc + HALF) >>> 34;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    function automatic longint rnd_dds();
        longint t;
        t = {$urandom(), $urandom()};
        return t >>> 29;
    endfunction

    // Handshakes are decided here, half a cycle before the edge that completes them.
    always @(negedge i_clock) begin
        if (!i_reset_n) begin
            sb.delete();
        end else begin
            if (o_dds_ready) dds_cnt++;
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", o_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out0", o_data0, mon_e.y0);
                    check("out1", o_data1, mon_e.y1);
                end
            end
            if (i_nco_restart) begin
                sb.delete();
            end else if (i_valid && o_ready) begin
                mon_e.y0 = mix(i_data_i0, i_data_q0, i_cos, i_sin);
                mon_e.y1 = mix(i_data_i1, i_data_q1, i_cos_d, i_sin_d);
                sb.push_back(mon_e);
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input longint i0, input longint q0, input longint i1, input longint q1,
                        input longint c0, input longint s0, input longint c1, input longint s1);
        bit ok;
        i_data_i0 = 16'(i0);
        i_data_q0 = 16'(q0);
        i_data_i1 = 16'(i1);
        i_data_q1 = 16'(q1);
        i_cos     = 36'(c0);
        i_sin     = 36'(s0);
        i_cos_d   = 36'(c1);
        i_sin_d   = 36'(s1);
        i_valid   = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge i_clock);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", o_ready, 1);
        tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            @(negedge i_clock);
            if (sb.size() == 0) break;
        end
        check("drain_empty", sb.size(), 0);
        tick();
    endtask

    task automatic restart();
        i_nco_restart = 1'b1;
        tick();
        i_nco_restart = 1'b0;
    endtask

    task automatic prime_check();
        int strobes;
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clock);
            if (o_dds_ready) strobes++;
            if (!o_primed) begin
                check("no_ready_prime", o_ready, 0);
                check("no_valid_prime", o_valid, 0);
            end
        end
        check("prime_strobes", strobes, 4);
        check("primed", o_primed, 1);
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic signed [15:0] h0, h1;

        i_reset_n     = 1'b0;
        i_nco_restart = 1'b0;
        i_valid       = 1'b0;
        i_ready       = 1'b1;
        {i_data_i0, i_data_q0, i_data_i1, i_data_q1} = '0;
        {i_cos, i_sin, i_cos_d, i_sin_d} = '0;

        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        check("rst_ready", o_ready, 0);
        check("rst_dds", o_dds_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_primed", o_primed, 0);
        check("rst_data0", o_data0, 0);
        check("rst_data1", o_data1, 0);
        tick();
        i_reset_n = 1'b1;

        // Valid input in IDLE is ignored.
        i_valid = 1'b1;
        tick();
        tick();
        @(negedge i_clock);
        check("idle_ready", o_ready, 0);
        check("idle_dds", o_dds_ready, 0);
        tick();
        i_valid = 1'b0;

        restart();
        prime_check();

        // DC tone and first-sample latency.
        send(16384, 0, 16384, 0, ONE, 0, ONE, 0);
        i_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clock);
            n++;
            if (o_valid) break;
        end
        check("latency", n, 4);
        tick();
        drain();

        // Saturation in both directions, rounding boundaries.
        send(-32768, -32768, -32768, -32768, ONE, -ONE, -ONE, ONE);
        send(32767, 32767, -32768, -32768, ONE, -ONE, -ONE, -ONE);
        send(1, 0, -1, 0, HALF, 0, HALF, 0);
        send(1, 0, 1, 0, HALF - 1, 0, HALF + 1, 0);
        send(0, 1, 0, -1, 0, -HALF, 0, HALF);
        i_valid = 1'b0;
        drain();

        // Random tones with random bubbles.
        for (int k = 0; k < 16; k++) begin
            send($signed(16'($urandom())), $signed(16'($urandom())),
                 $signed(16'($urandom())), $signed(16'($urandom())),
                 rnd_dds(), rnd_dds(), rnd_dds(), rnd_dds());
            if ($urandom_range(0, 3) == 0) begin
                i_valid = 1'b0;
                tick();
            end
        end
        i_valid = 1'b0;
        drain();

        // Backpressure mid-stream.
        dds_cnt = 0;
        acc_cnt = 0;
        fork
            begin
                for (int k = 0; k < 20; k++)
                    send($signed(16'($urandom())), $signed(16'($urandom())),
                         $signed(16'($urandom())), $signed(16'($urandom())),
                         rnd_dds(), rnd_dds(), rnd_dds(), rnd_dds());
                i_valid = 1'b0;
            end
            begin
                repeat (6) tick();
                i_ready = 1'b0;
                @(negedge i_clock);
                h0 = o_data0;
                h1 = o_data1;
                for (int k = 0; k < 9; k++) begin
                    @(negedge i_clock);
                    check("bp_hold0", o_data0, h0);
                    check("bp_hold1", o_data1, h1);
                    check("bp_valid", o_valid, 1);
                    check("bp_dds", o_dds_ready, 0);
                    check("bp_ready", o_ready, 0);
                end
                @(posedge i_clock);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();
        check("bp_accepts", acc_cnt, 20);
        check("dds_eq_accepts", dds_cnt, acc_cnt);

        // Restart with a full, stalled pipeline.
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(100 * (k + 1), 0, -100 * (k + 1), 0, ONE, 0, ONE, 0);
        i_valid = 1'b0;
        tick();
        tick();
        i_ready = 1'b1;
        restart();
        @(negedge i_clock);
        check("flush_valid", o_valid, 0);
        prime_check();
        send(-1234, 0, 4321, 0, ONE, 0, ONE, 0);
        i_valid = 1'b0;
        drain();

        // Asynchronous reset mid-stream; no re-prime until the next restart.
        send(500, 0, 600, 0, ONE, 0, ONE, 0);
        send(700, 0, 800, 0, ONE, 0, ONE, 0);
        i_valid = 1'b0;
        tick();
        tick();
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_primed", o_primed, 0);
        check("arst_data0", o_data0, 0);
        tick();
        i_reset_n = 1'b1;
        repeat (8) tick();
        @(negedge i_clock);
        check("post_rst_primed", o_primed, 0);
        check("post_rst_dds", o_dds_ready, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
